// File: rtl/board_if.sv
// Bundle of button, card-array and cursor signals between the board
// controller and its surroundings (debounced buttons in, per-card pulses out).
interface board_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int FACE_W = 3
);
  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(N / 2 + 1);

  logic                  btn_up;
  logic                  btn_down;
  logic                  btn_left;
  logic                  btn_right;
  logic                  btn_s;
  logic [N*FACE_W-1:0]   faces;
  logic [N-1:0]          hidden;
  logic [N-1:0]          cur;
  logic [N-1:0]          s;
  logic [N-1:0]          mf;
  logic [N-1:0]          ms;
  logic [RW-1:0]         cur_row;
  logic [CW-1:0]         cur_col;
  logic [PW-1:0]         pairs_left;
  logic                  win;

  // Environment side: drives buttons and card state, observes controller outputs.
  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_s, faces, hidden,
    input  cur, s, mf, ms, cur_row, cur_col, pairs_left, win
  );

  // Controller side.
  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_s, faces, hidden,
    output cur, s, mf, ms, cur_row, cur_col, pairs_left, win
  );
endinterface

// File: rtl/board_ctrl.sv
// Board controller for the link-link card game: owns the cursor, routes
// selections to the card under it, pairs two selections, compares their faces
// and issues match-success / match-failure pulses. Tracks pairs left and win.
module board_ctrl #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int FACE_W = 3
) (
  input  logic   clk,
  input  logic   rst,
  board_if.slave bus
);
  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(N / 2 + 1);

  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [PW-1:0] PAIRS_INIT = PW'(N / 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ONE    = 3'd1,
    CHECK  = 3'd2,
    RESULT = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [N-1:0]    cur_q, cur_d;
  logic [N-1:0]    s_q, s_d;
  logic [N-1:0]    mf_q, mf_d;
  logic [N-1:0]    ms_q, ms_d;
  logic [PW-1:0]   pairs_q, pairs_d;
  logic            win_q, win_d;
  logic [IW-1:0]   first_q, first_d;
  logic [IW-1:0]   second_q, second_d;
  logic            eq_q, eq_d;

  logic [IW-1:0]     cur_idx_s;
  logic [IW-1:0]     next_idx_s;
  logic              move_en_s;
  logic              sel_ok_s;
  logic [FACE_W-1:0] face_a_s;
  logic [FACE_W-1:0] face_b_s;

  // Single-bit vector with bit idx set; used for cursor and card pulses.
  function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
    logic [N-1:0] v;
    v      = {N{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Linear card index under the cursor and the two latched face values.
  always_comb begin
    cur_idx_s = IW'(row_q) * IW'(COLS) + IW'(col_q);
    sel_ok_s  = bus.btn_s & ~bus.hidden[cur_idx_s];
    face_a_s  = bus.faces[first_q * FACE_W +: FACE_W];
    face_b_s  = bus.faces[second_q * FACE_W +: FACE_W];
  end

  // Next-state logic: pairing FSM, result pulses, pair counter and cursor moves.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    s_d       = {N{1'b0}};
    mf_d      = {N{1'b0}};
    ms_d      = {N{1'b0}};
    pairs_d   = pairs_q;
    win_d     = win_q;
    first_d   = first_q;
    second_d  = second_q;
    eq_d      = eq_q;
    move_en_s = 1'b0;

    case (state_q)
      IDLE: begin
        move_en_s = 1'b1;
        if (sel_ok_s) begin
          s_d     = onehot(cur_idx_s);
          first_d = cur_idx_s;
          state_d = ONE;
        end else begin
          state_d = IDLE;
        end
      end
      ONE: begin
        move_en_s = 1'b1;
        if (sel_ok_s) begin
          s_d = onehot(cur_idx_s);
          if (cur_idx_s == first_q) begin
            state_d = IDLE;
          end else begin
            second_d = cur_idx_s;
            state_d  = CHECK;
          end
        end else begin
          state_d = ONE;
        end
      end
      CHECK: begin
        eq_d    = (face_a_s == face_b_s);
        state_d = RESULT;
      end
      RESULT: begin
        if (eq_q) begin
          ms_d = onehot(first_q) | onehot(second_q);
          if (pairs_q <= PW'(1)) begin
            pairs_d = {PW{1'b0}};
            win_d   = 1'b1;
            state_d = DONE;
          end else begin
            pairs_d = pairs_q - PW'(1);
            state_d = IDLE;
          end
        end else begin
          mf_d    = onehot(first_q) | onehot(second_q);
          state_d = IDLE;
        end
      end
      DONE: begin
        win_d   = 1'b1;
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A select press in the same cycle always swallows any move.
    if (move_en_s && !bus.btn_s) begin
      if (bus.btn_up) begin
        row_d = (row_q == {RW{1'b0}}) ? ROW_LAST : row_q - RW'(1);
      end else if (bus.btn_down) begin
        row_d = (row_q == ROW_LAST) ? {RW{1'b0}} : row_q + RW'(1);
      end else if (bus.btn_left) begin
        col_d = (col_q == {CW{1'b0}}) ? COL_LAST : col_q - CW'(1);
      end else if (bus.btn_right) begin
        col_d = (col_q == COL_LAST) ? {CW{1'b0}} : col_q + CW'(1);
      end else begin
        row_d = row_q;
      end
    end else begin
      row_d = row_q;
    end

    next_idx_s = IW'(row_d) * IW'(COLS) + IW'(col_d);
    cur_d      = onehot(next_idx_s);
  end

  // State and output registers; reset aborts any pair in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= {RW{1'b0}};
      col_q    <= {CW{1'b0}};
      cur_q    <= {{(N-1){1'b0}}, 1'b1};
      s_q      <= {N{1'b0}};
      mf_q     <= {N{1'b0}};
      ms_q     <= {N{1'b0}};
      pairs_q  <= PAIRS_INIT;
      win_q    <= 1'b0;
      first_q  <= {IW{1'b0}};
      second_q <= {IW{1'b0}};
      eq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      cur_q    <= cur_d;
      s_q      <= s_d;
      mf_q     <= mf_d;
      ms_q     <= ms_d;
      pairs_q  <= pairs_d;
      win_q    <= win_d;
      first_q  <= first_d;
      second_q <= second_d;
      eq_q     <= eq_d;
    end
  end

  assign bus.cur        = cur_q;
  assign bus.s          = s_q;
  assign bus.mf         = mf_q;
  assign bus.ms         = ms_q;
  assign bus.cur_row    = row_q;
  assign bus.cur_col    = col_q;
  assign bus.pairs_left = pairs_q;
  assign bus.win        = win_q;
endmodule

// File: tb/tb_board_ctrl.sv
// Directed bench for board_ctrl on a 4x4 board: cursor wrap and priority,
// select/deselect, match and mismatch timing, hidden cards, win and reset abort.
module tb_board_ctrl;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int FACE_W = 3;
  localparam int N      = ROWS * COLS;

  // button masks {up, down, left, right, s}
  localparam logic [4:0] B_UP    = 5'b10000;
  localparam logic [4:0] B_DOWN  = 5'b01000;
  localparam logic [4:0] B_LEFT  = 5'b00100;
  localparam logic [4:0] B_RIGHT = 5'b00010;
  localparam logic [4:0] B_S     = 5'b00001;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   mrow   = 0;
  int   mcol   = 0;
  int   fv [N] = '{0, 1, 2, 3, 1, 0, 3, 2, 4, 5, 6, 7, 5, 4, 7, 6};

  board_if #(.ROWS(ROWS), .COLS(COLS), .FACE_W(FACE_W)) bus ();

  board_ctrl #(.ROWS(ROWS), .COLS(COLS), .FACE_W(FACE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] b);
    bus.btn_up    = b[4];
    bus.btn_down  = b[3];
    bus.btn_left  = b[2];
    bus.btn_right = b[1];
    bus.btn_s     = b[0];
    tick();
    bus.btn_up    = 1'b0;
    bus.btn_down  = 1'b0;
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_s     = 1'b0;
  endtask

  function automatic logic [31:0] bit_of(input int idx);
    logic [31:0] one;
    one = 32'd1;
    return one << idx;
  endfunction

  task automatic goto(input int r, input int c);
    while (mrow != r) begin
      press(B_DOWN);
      mrow = (mrow + 1) % ROWS;
    end
    while (mcol != c) begin
      press(B_RIGHT);
      mcol = (mcol + 1) % COLS;
    end
    chk("goto_cur", 32'(bus.cur), bit_of(r * COLS + c));
  endtask

  task automatic match_pair(input int a, input int b, input int exp_pairs);
    goto(a / COLS, a % COLS);
    press(B_S);
    chk("pair_s_first", 32'(bus.s), bit_of(a));
    goto(b / COLS, b % COLS);
    press(B_S);
    chk("pair_s_second", 32'(bus.s), bit_of(b));
    tick();
    chk("pair_ms_early", 32'(bus.ms), 32'h0);
    tick();
    chk("pair_ms", 32'(bus.ms), bit_of(a) | bit_of(b));
    chk("pair_mf", 32'(bus.mf), 32'h0);
    chk("pair_left", 32'(bus.pairs_left), 32'(exp_pairs));
    bus.hidden[a] = 1'b1;
    bus.hidden[b] = 1'b1;
    tick();
    chk("pair_ms_end", 32'(bus.ms), 32'h0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.btn_up    = 1'b0;
    bus.btn_down  = 1'b0;
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_s     = 1'b0;
    bus.hidden    = '0;
    for (int i = 0; i < N; i++) bus.faces[i*FACE_W +: FACE_W] = 3'(fv[i]);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // reset state
    chk("rst_cur", 32'(bus.cur), 32'h0001);
    chk("rst_pairs", 32'(bus.pairs_left), 32'd8);
    chk("rst_win", 32'(bus.win), 32'd0);
    chk("rst_s", 32'(bus.s), 32'h0);
    chk("rst_mf", 32'(bus.mf), 32'h0);
    chk("rst_ms", 32'(bus.ms), 32'h0);

    // cursor wrap and move priority
    press(B_UP);
    mrow = 3;
    chk("up_wrap_row", 32'(bus.cur_row), 32'd3);
    chk("up_wrap_cur", 32'(bus.cur), 32'h1000);
    press(B_LEFT);
    mcol = 3;
    chk("left_wrap_col", 32'(bus.cur_col), 32'd3);
    chk("left_wrap_cur", 32'(bus.cur), 32'h8000);
    goto(1, 1);
    press(B_UP | B_RIGHT);
    mrow = 0;
    chk("prio_row", 32'(bus.cur_row), 32'd0);
    chk("prio_col", 32'(bus.cur_col), 32'd1);
    chk("prio_cur", 32'(bus.cur), 32'h0002);

    // mismatch idx0/idx1, with a move dropped while checking
    goto(0, 0);
    press(B_S);
    chk("mm_s0", 32'(bus.s), 32'h0001);
    chk("mm_cur0", 32'(bus.cur), 32'h0001);
    tick();
    chk("mm_s0_end", 32'(bus.s), 32'h0);
    goto(0, 1);
    press(B_S);
    chk("mm_s1", 32'(bus.s), 32'h0002);
    press(B_RIGHT);
    chk("mm_drop_col", 32'(bus.cur_col), 32'd1);
    chk("mm_mf_early", 32'(bus.mf), 32'h0);
    tick();
    chk("mm_mf", 32'(bus.mf), 32'h0003);
    chk("mm_ms", 32'(bus.ms), 32'h0);
    chk("mm_pairs", 32'(bus.pairs_left), 32'd8);
    tick();
    chk("mm_mf_end", 32'(bus.mf), 32'h0);

    // match idx0/idx5
    match_pair(0, 5, 7);

    // select then deselect idx2
    goto(0, 2);
    press(B_S);
    chk("desel_s_a", 32'(bus.s), 32'h0004);
    press(B_S);
    chk("desel_s_b", 32'(bus.s), 32'h0004);
    tick();
    chk("desel_s_end", 32'(bus.s), 32'h0);
    tick();
    tick();
    chk("desel_mf", 32'(bus.mf), 32'h0);
    chk("desel_ms", 32'(bus.ms), 32'h0);

    // select on hidden card, select beats move
    goto(0, 0);
    press(B_S);
    chk("hid_s", 32'(bus.s), 32'h0);
    press(B_S | B_DOWN);
    chk("sel_move_row", 32'(bus.cur_row), 32'd0);
    chk("sel_move_cur", 32'(bus.cur), 32'h0001);
    tick();
    chk("hid_mf", 32'(bus.mf), 32'h0);
    chk("hid_ms", 32'(bus.ms), 32'h0);

    // remaining pairs to win
    match_pair(1, 4, 6);
    match_pair(2, 7, 5);
    match_pair(3, 6, 4);
    match_pair(8, 13, 3);
    match_pair(9, 12, 2);
    match_pair(10, 15, 1);
    match_pair(11, 14, 0);
    chk("win", 32'(bus.win), 32'd1);
    chk("win_pairs", 32'(bus.pairs_left), 32'd0);
    press(B_RIGHT);
    chk("done_cur", 32'(bus.cur), 32'h4000);
    bus.hidden[0] = 1'b0;
    press(B_S);
    chk("done_s", 32'(bus.s), 32'h0);
    chk("done_win", 32'(bus.win), 32'd1);

    // reset during CHECK aborts the pair
    rst = 1'b1;
    #1;
    rst = 1'b0;
    bus.hidden = '0;
    mrow = 0;
    mcol = 0;
    tick();
    chk("rst2_win", 32'(bus.win), 32'd0);
    press(B_S);
    chk("abort_s0", 32'(bus.s), 32'h0001);
    goto(1, 1);
    press(B_S);
    chk("abort_s5", 32'(bus.s), 32'h0020);
    rst = 1'b1;
    #1;
    chk("abort_s_clr", 32'(bus.s), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("abort_ms", 32'(bus.ms), 32'h0);
    tick();
    chk("abort_ms2", 32'(bus.ms), 32'h0);
    chk("abort_mf", 32'(bus.mf), 32'h0);
    chk("abort_cur", 32'(bus.cur), 32'h0001);
    chk("abort_pairs", 32'(bus.pairs_left), 32'd8);
    chk("abort_win", 32'(bus.win), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
